// File: rtl/phy_serdes_lanes.sv
// phy_serdes_lanes: multi-lane comma-aligned serializer/deserializer; define LOOPBACK_EN to add a TX-to-RX loopback input
module phy_serdes_lanes #(
    parameter int           LANES       = 2,
    parameter int           W           = 8,
    parameter logic [W-1:0] COMMA       = W'(8'hBC),
    parameter logic [W-1:0] IDLE        = W'(8'h7C),
    parameter int           SYNC_WORDS  = 4,
    parameter int           TX_PREAMBLE = 8
) (
    input  logic                 clk_8f,
    input  logic                 reset,
`ifdef LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic [LANES*W-1:0]   data_in,
    input  logic [LANES-1:0]     valid_in,
    output logic                 word_tick,
    output logic                 tx_ready,
    output logic [LANES-1:0]     serial_out,
    input  logic [LANES-1:0]     serial_in,
    output logic [LANES*W-1:0]   data_out,
    output logic [LANES-1:0]     valid_out,
    output logic [LANES-1:0]     rx_active
);
    localparam int CW = $clog2(W);
    localparam int PW = $clog2(TX_PREAMBLE + 1);
    localparam int SW = $clog2(SYNC_WORDS + 1);
    localparam logic [CW-1:0] LAST     = CW'(W - 1);
    localparam logic [PW-1:0] PRE_END  = PW'(TX_PREAMBLE);
    localparam logic [SW-1:0] SYNC_END = SW'(SYNC_WORDS);
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] ALIGN  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;

    assign word_tick = cnt_q == LAST;
    assign tx_ready  = pre_q == PRE_END;

    // word counter wraps every W cycles; preamble count saturates once the last comma is loaded
    always_comb begin
        cnt_d = word_tick ? '0 : cnt_q + 1'b1;
        pre_d = (word_tick && !tx_ready) ? pre_q + 1'b1 : pre_q;
    end

    // timing state shared by every lane
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            pre_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [W-1:0]  tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
        logic [1:0]    st_q, st_d;
        logic [CW-1:0] ph_q, ph_d;
        logic [SW-1:0] cc_q, cc_d;
        logic          vld_q, vld_d, rx_bit, bnd;
`ifdef LOOPBACK_EN
        assign rx_bit = loopback ? tx_q[W-1] : serial_in[i];
`else
        assign rx_bit = serial_in[i];
`endif
        assign bnd                = ph_q == LAST;
        assign serial_out[i]      = tx_q[W-1];
        assign data_out[i*W +: W] = dout_q;
        assign valid_out[i]       = vld_q;
        assign rx_active[i]       = st_q == ACTIVE;

        // TX loads a whole word on the tick and otherwise shifts MSB-first; RX shifts in at the LSB
        always_comb begin
            tx_d = word_tick ? (!tx_ready ? COMMA : valid_in[i] ? data_in[i*W +: W] : IDLE) : {tx_q[W-2:0], 1'b0};
            rx_d = {rx_q[W-2:0], rx_bit};
        end

        // alignment FSM: hunt for a comma at any offset, confirm it at word spacing, then deliver data words
        always_comb begin
            st_d   = st_q;
            ph_d   = bnd ? '0 : ph_q + 1'b1;
            cc_d   = cc_q;
            dout_d = dout_q;
            vld_d  = 1'b0;
            if (st_q == SEARCH) begin
                if (rx_q == COMMA) begin
                    ph_d = '0;
                    cc_d = SW'(1);
                    st_d = ALIGN;
                end
            end else if (bnd) begin
                if (st_q == ALIGN) begin
                    if (rx_q == COMMA) begin
                        cc_d = cc_q + 1'b1;
                        st_d = (cc_d == SYNC_END) ? ACTIVE : ALIGN;
                    end else begin
                        cc_d = '0;
                        st_d = SEARCH;
                    end
                end else if (rx_q != COMMA && rx_q != IDLE) begin
                    dout_d = rx_q;
                    vld_d  = 1'b1;
                end
            end
        end

        // per-lane TX/RX registers
        always_ff @(posedge clk_8f or negedge reset) begin
            if (!reset) begin
                tx_q   <= '0;
                rx_q   <= '0;
                dout_q <= '0;
                st_q   <= SEARCH;
                ph_q   <= '0;
                cc_q   <= '0;
                vld_q  <= 1'b0;
            end else begin
                tx_q   <= tx_d;
                rx_q   <= rx_d;
                dout_q <= dout_d;
                st_q   <= st_d;
                ph_q   <= ph_d;
                cc_q   <= cc_d;
                vld_q  <= vld_d;
            end
        end
    end
endmodule

// File: tb/tb_phy_serdes_lanes.sv
// tb_phy_serdes_lanes: randomized traffic against a timeline model of phy_serdes_lanes; loopback steps run when LOOPBACK_EN is defined
module tb_phy_serdes_lanes;
    localparam int LANES = 2;
    localparam int W = 8;
    localparam int SYNC = 4;
    localparam int PRE = 8;
    localparam logic [W-1:0] COMMA = 8'hBC;
    localparam logic [W-1:0] IDLE = 8'h7C;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [LANES*W-1:0] data_in = '0;
    logic [LANES*W-1:0] data_out;
    logic [LANES-1:0] valid_in = '0;
    logic [LANES-1:0] serial_out, serial_in, valid_out, rx_active;
    logic word_tick, tx_ready;
`ifdef LOOPBACK_EN
    logic loopback = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int n = 0;
    int dly [LANES];
    logic [15:0] line [LANES];
    bit inj = 1'b0;
    logic [LANES-1:0] inj_bits = '0;
    bit model_rx = 1'b1;
    bit dead = 1'b0;
    bit exp_vld [LANES][1024];
    logic [W-1:0] exp_dat [LANES][1024];
    logic [W-1:0] txw [LANES][256];
    logic [W-1:0] exp_d [LANES];
    int strobes [LANES];
    int first_t [LANES];
    bit fixed_en = 1'b0;
    logic [LANES*W-1:0] fixed_d = '0;
    bit bq [$];

    always #5 clk = ~clk;

    phy_serdes_lanes #(
        .LANES(LANES), .W(W), .COMMA(COMMA), .IDLE(IDLE),
        .SYNC_WORDS(SYNC), .TX_PREAMBLE(PRE)
    ) dut (
        .clk_8f(clk),
        .reset(reset),
`ifdef LOOPBACK_EN
        .loopback(loopback),
`endif
        .data_in(data_in),
        .valid_in(valid_in),
        .word_tick(word_tick),
        .tx_ready(tx_ready),
        .serial_out(serial_out),
        .serial_in(serial_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .rx_active(rx_active)
    );

    // channel: a chain of flops per lane, tapped at the lane's delay
    always @(posedge clk) begin
        for (int i = 0; i < LANES; i++) line[i] <= {line[i][14:0], serial_out[i]};
    end

    // serial_in comes from the delayed channel, or from injected bits
    always_comb begin
        serial_in = '0;
        for (int i = 0; i < LANES; i++)
            serial_in[i] = inj ? inj_bits[i] : (dly[i] == 0 ? serial_out[i] : line[i][dly[i]-1]);
    end

    task automatic chk(input string tag, input int lane, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s lane%0d obs=%0h exp=%0h n=%0d", tag, lane, obs, expv, n);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int b = W - 1; b >= 0; b--) bq.push_back(w[b]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        valid_in = '0;
        data_in = '0;
        repeat (10) @(negedge clk);
        chk("rst_word_tick", 0, word_tick, 0);
        chk("rst_tx_ready", 0, tx_ready, 0);
        chk("rst_serial_out", 0, serial_out, 0);
        chk("rst_data_out", 0, data_out, 0);
        chk("rst_valid_out", 0, valid_out, 0);
        chk("rst_rx_active", 0, rx_active, 0);
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < 1024; j++) begin exp_vld[i][j] = 1'b0; exp_dat[i][j] = '0; end
            for (int j = 0; j < 256; j++) txw[i][j] = '0;
            exp_d[i] = '0;
            strobes[i] = 0;
            first_t[i] = -1;
        end
        n = 0;
        reset = 1'b1;
    endtask

    // one cycle: compare outputs at cycle n against the model, then drive the next inputs
    task automatic step(input int pol);
        logic [W-1:0] d;
        logic v;
        bit e;
        int k;
        chk("word_tick", 0, word_tick, n % W == W - 1);
        chk("tx_ready", 0, tx_ready, n >= PRE * W);
        for (int i = 0; i < LANES; i++) begin
            e = 1'b0;
            if (n >= W) e = txw[i][n / W - 1][W - 1 - n % W];
            chk("serial_out", i, serial_out[i], e);
            if (model_rx) begin
                if (exp_vld[i][n]) exp_d[i] = exp_dat[i][n];
                chk("valid_out", i, valid_out[i], exp_vld[i][n]);
                chk("data_out", i, data_out[i*W +: W], exp_d[i]);
                chk("rx_active", i, rx_active[i], n >= (SYNC + 1) * W + dly[i] + 1);
            end
            if (dead) begin
                chk("dead_rx_active", i, rx_active[i], 0);
                chk("dead_valid_out", i, valid_out[i], 0);
            end
            if (valid_out[i]) begin
                strobes[i]++;
                if (first_t[i] < 0) first_t[i] = n;
            end
        end
        if (n % W == W - 1) begin
            k = n / W;
            for (int i = 0; i < LANES; i++) begin
                v = pol == 0 ? 1'b1 : pol == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
                d = W'($urandom);
                if (fixed_en && k == PRE) begin v = 1'b1; d = fixed_d[i*W +: W]; end
                valid_in[i] = v;
                data_in[i*W +: W] = d;
                txw[i][k] = k < PRE ? COMMA : v ? d : IDLE;
                if (k >= PRE && v && d != COMMA && d != IDLE) begin
                    exp_vld[i][n + W + 2 + dly[i]] = 1'b1;
                    exp_dat[i][n + W + 2 + dly[i]] = d;
                end
            end
        end
        if (inj) begin
            e = 1'b0;
            if (bq.size() > 0) e = bq.pop_front();
            inj_bits = {LANES{e}};
        end
        @(negedge clk);
        n++;
    endtask

    task automatic run(input int words, input int pol);
        repeat (words * W) step(pol);
    endtask

    initial begin
        int plen, total;
        dly[0] = 0;
        dly[1] = 0;
        // direct wire, fixed first words then random and idle traffic
        fixed_en = 1'b1;
        fixed_d = {8'h55, 8'h3A};
        do_reset();
        run(PRE + 10, 0);
        run(5, 2);
        run(10, 1);
        run(3, 2);
        chk("first_strobe_t", 0, first_t[0], (PRE + 1) * W - 1 + W + 2);
        chk("first_strobe_t", 1, first_t[1], (PRE + 1) * W - 1 + W + 2);
        // per-lane channel skew
        dly[0] = 6;
        dly[1] = 2;
        do_reset();
        run(PRE + 10, 1);
        run(3, 2);
        chk("skew", 0, first_t[0] - first_t[1], 4);
        dly[0] = 0;
        dly[1] = 0;
        // injected stream: false comma, garbage, then a proper comma run and one data word
        inj = 1'b1;
        model_rx = 1'b0;
        do_reset();
        bq.delete();
        repeat (5) bq.push_back(1'b0);
        push_word(COMMA);
        push_word(8'h00);
        repeat (3) bq.push_back(1'b0);
        repeat (SYNC - 1) push_word(COMMA);
        plen = bq.size();
        push_word(COMMA);
        push_word(8'h3A);
        push_word(IDLE);
        push_word(IDLE);
        total = bq.size();
        while (bq.size() > 0) begin
            dead = (total - bq.size()) <= plen;
            step(2);
        end
        dead = 1'b0;
        chk("inj_rx_active", 0, rx_active, 2'b11);
        chk("inj_data", 0, data_out[7:0], 8'h3A);
        chk("inj_data", 1, data_out[15:8], 8'h3A);
        chk("inj_strobes", 0, strobes[0], 1);
        chk("inj_strobes", 1, strobes[1], 1);
        inj = 1'b0;
        model_rx = 1'b1;
        // reset mid-word while ACTIVE, then full restart
        do_reset();
        run(PRE + 4, 0);
        #2 reset = 1'b0;
        #1;
        chk("mid_word_tick", 0, word_tick, 0);
        chk("mid_tx_ready", 0, tx_ready, 0);
        chk("mid_serial_out", 0, serial_out, 0);
        chk("mid_data_out", 0, data_out, 0);
        chk("mid_valid_out", 0, valid_out, 0);
        chk("mid_rx_active", 0, rx_active, 0);
        do_reset();
        run(PRE + 6, 1);
        run(2, 2);
        chk("relock", 0, rx_active, 2'b11);
`ifdef LOOPBACK_EN
        inj = 1'b1;
        inj_bits = '0;
        loopback = 1'b1;
        fixed_d = {8'h5A, 8'hA5};
        do_reset();
        run(PRE + 1, 2);
        run(2, 2);
        chk("lb_data", 0, data_out[7:0], 8'hA5);
        chk("lb_strobes", 0, strobes[0], 1);
        loopback = 1'b0;
        model_rx = 1'b0;
        dead = 1'b1;
        do_reset();
        run(PRE + 4, 0);
        dead = 1'b0;
        model_rx = 1'b1;
        inj = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/phy_serdes_lanes.md
Name: phy_serdes_lanes

Overview:
Parametrised multi-lane serial PHY that generalises the fixed 2-lane, 8-bit phy. Per lane, a TX serializer sends a COMMA preamble and then data or IDLE words MSB-first, one bit per clk_8f. Per lane, an RX deserializer finds COMMA at any bit offset, locks word alignment after SYNC_WORDS consecutive aligned commas, and delivers words with a valid strobe. Everything runs on one clock; the internal word tick replaces the separate clock generator, and lanes align independently, so inter-lane skew is tolerated.

Parameters:
LANES, 2, number of serial lanes (1..8)
W, 8, word width in bits (4..16)
COMMA, 8'hBC, alignment symbol (W bits)
IDLE, 8'h7C, filler symbol sent when no valid data (W bits; must differ from COMMA)
SYNC_WORDS, 4, consecutive aligned commas needed for RX lock (2..15)
TX_PREAMBLE, 8, COMMA words TX sends after reset before accepting data (must be >= SYNC_WORDS)

Ports:
clk_8f  in  1  bit clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
data_in  in  LANES*W  TX words; lane i at [i*W +: W]
valid_in  in  LANES  per-lane TX valid, sampled on word_tick
word_tick  out  1  one-cycle pulse every W cycles; TX samples data_in/valid_in on this cycle
tx_ready  out  1  high once the preamble completes
serial_out  out  LANES  TX serial bit per lane
serial_in  in  LANES  RX serial bit per lane
data_out  out  LANES*W  last received data word per lane (held)
valid_out  out  LANES  one-cycle strobe per received data word
rx_active  out  LANES  lane locked (ACTIVE)

Behaviour:
- Reset (reset=0, async) sets:
  - word counter=0, word_tick=0, tx_ready=0
  - serial_out=0, data_out=0, valid_out=0, rx_active=0
  - preamble counter=0; all RX FSMs to SEARCH with counters cleared.
- Word counter counts 0..W-1 and wraps. word_tick=1 when the counter is W-1. The first tick comes W cycles after reset release.
- TX, on word_tick, loads the shift register per lane:
  - COMMA while preamble count < TX_PREAMBLE; the count increments on each tick.
  - Otherwise data_in lane if valid_in[i], else IDLE.
- tx_ready rises in the cycle after the tick that loads the last preamble word. It stays high until reset.
- serial_out = shift register MSB. The loaded word's MSB appears the cycle after word_tick, and one bit shifts per cycle. Load and shift never conflict: load wins on the tick.
- RX shift register: each cycle it shifts serial_in in at the LSB.
- RX FSM per lane:
  - SEARCH: compares the shift register to COMMA every cycle. On match, phase counter=0, comma count=1, go to ALIGN.
  - ALIGN: at each aligned boundary (phase counter wraps, i.e. every W cycles):
    - word==COMMA: count++; when count reaches SYNC_WORDS, go to ACTIVE and set rx_active=1 in the same update.
    - any other word: count=0, go to SEARCH.
  - ACTIVE: at each aligned boundary:
    - word==COMMA or word==IDLE: no strobe, data_out holds.
    - otherwise: data_out lane=word and valid_out=1 for exactly one cycle, registered in the cycle after the boundary.
    - ACTIVE is left only by reset.
- Latency, with serial_out wired directly to serial_in: word sampled on word_tick at cycle t gives valid_out at t+W+2. Each flop of channel delay adds 1 cycle.
- Lanes are independent. Different skews give different valid_out timing per lane; no deskew is performed.
- Reset mid-word discards partial words on both sides. After release, TX restarts the preamble and RX restarts SEARCH.
- A spurious COMMA match in SEARCH that fails in ALIGN returns to SEARCH without output.

Optional Feature:
LOOPBACK_EN:
- When defined, adds input loopback (1 bit). loopback=1 makes the RX of lane i consume serial_out[i] instead of serial_in[i]; loopback is sampled combinationally at the mux.
- When not defined, the port and mux do not exist and RX always uses serial_in.

Test Plan:
1. Direct wire LANES=2, W=8; after preamble send lane0 0x3A, lane1 0x55 -> rx_active=2'b11 before 8 words; data_out 0x3A/0x55 with valid_out strobe at t+10.
2. Lane0 delay 6 flops, lane1 delay 2 -> both lock; valid_out[0] occurs 4 cycles after valid_out[1]; data correct.
3. valid_in=0 after preamble for 5 words -> serial sends 0x7C; no valid_out; data_out holds previous value.
4. Inject serial_in pattern with a mid-stream 0xBC at a wrong offset followed by non-comma -> FSM SEARCH->ALIGN->SEARCH; rx_active stays 0.
5. Assert reset=0 mid-word in ACTIVE -> all outputs 0 immediately; after release, preamble of 8 commas resent and relock occurs.
6. LOOPBACK_EN defined, loopback=1, serial_in tied 0 -> 0xA5 on lane0 received with valid_out; loopback=0 -> lane never leaves SEARCH.
